// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and memory-controller-side signals of the sprite DMA sequencer.
// The slave modport is the DMA block; the master modport is whatever drives the CPU/memory pins.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic        cpu_stall;
  logic        dma_busy;
  logic [15:0] mem_addr_out;
  logic [7:0]  mem_data_out;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [7:0]  mem_data_in;

  modport slave (
    input  cpu_addr_in, cpu_data_in, cpu_write_en, cpu_read_en, mem_data_in,
    output cpu_stall, dma_busy, mem_addr_out, mem_data_out, mem_write_en, mem_read_en
  );

  modport master (
    output cpu_addr_in, cpu_data_in, cpu_write_en, cpu_read_en, mem_data_in,
    input  cpu_stall, dma_busy, mem_addr_out, mem_data_out, mem_write_en, mem_read_en
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: a CPU write to DMA_REG_ADDR stalls the CPU and copies a 256-byte page
// into sprite RAM through OAM_DATA_ADDR. Transparent pass-through when idle.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic           clk,
  input logic           rst,
  oam_dma_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StDummy,
    StAlign,
    StRead,
    StWrite
  } state_e;

  state_e      state_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic        odd_q;
  logic        busy_q;
  logic        trigger;

  assign trigger = (state_q == StIdle) && bus.cpu_write_en && (bus.cpu_addr_in == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      odd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      odd_q <= ~odd_q;
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            page_q  <= bus.cpu_data_in;
            idx_q   <= 8'h00;
            state_q <= StDummy;
            busy_q  <= 1'b1;
          end
        end
        // An odd cycle here costs one extra ALIGN so reads land on even cycles.
        StDummy: state_q <= odd_q ? StAlign : StRead;
        StAlign: state_q <= StRead;
        StRead:  state_q <= StWrite;
        StWrite: begin
          if (idx_q == 8'hFF) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            idx_q   <= idx_q + 8'h01;
            state_q <= StRead;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_stall = busy_q;
  assign bus.dma_busy  = busy_q;

  always_comb begin
    bus.mem_addr_out = bus.cpu_addr_in;
    bus.mem_data_out = bus.cpu_data_in;
    bus.mem_write_en = 1'b0;
    bus.mem_read_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.mem_read_en  = bus.cpu_read_en;
        // The trigger write is consumed here, never forwarded to memory.
        bus.mem_write_en = bus.cpu_write_en && (bus.cpu_addr_in != DMA_REG_ADDR);
      end
      StRead: begin
        bus.mem_addr_out = {page_q, idx_q};
        bus.mem_read_en  = 1'b1;
      end
      StWrite: begin
        bus.mem_addr_out = OAM_DATA_ADDR;
        bus.mem_data_out = bus.mem_data_in;
        bus.mem_write_en = 1'b1;
      end
      default: begin
        bus.mem_write_en = 1'b0;
        bus.mem_read_en  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: timeline model of the transfer checked every cycle,
// plus a small memory/sprite-RAM model and hand-computed literal expectations.
module tb_oam_dma_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: registered read of a pattern derived from the address.
  logic [7:0] key = 8'h00;
  function automatic logic [7:0] mem_val(input logic [15:0] a, input logic [7:0] k);
    return a[7:0] ^ k;
  endfunction

  always @(posedge clk) begin
    if (!rst) bus.mem_data_in <= 8'h00;
    else if (bus.mem_read_en) bus.mem_data_in <= mem_val(bus.mem_addr_out, key);
  end

  // Sprite RAM model with a $2003 pointer and $2004 auto-increment data port.
  logic [7:0] oam [256];
  logic [7:0] oam_ptr = 8'h00;
  always @(posedge clk) begin
    if (rst && bus.mem_write_en) begin
      if (bus.mem_addr_out == 16'h2003) oam_ptr <= bus.mem_data_out;
      else if (bus.mem_addr_out == 16'h2004) begin
        oam[oam_ptr] <= bus.mem_data_out;
        oam_ptr      <= oam_ptr + 8'h01;
      end
    end
  end

  // Transfer timeline model: k counts cycles since the trigger edge.
  bit         m_active = 1'b0;
  int         m_k      = 0;
  int         m_len    = 0;
  bit         m_align  = 1'b0;
  logic [7:0] m_page   = 8'h00;
  int         ecount   = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      ecount   <= 0;
    end else begin
      ecount <= ecount + 1;
      if (m_active) begin
        if (m_k == m_len) m_active <= 1'b0;
        else m_k <= m_k + 1;
      end else if (bus.cpu_write_en && bus.cpu_addr_in == 16'h4014) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_page   <= bus.cpu_data_in;
        m_align  <= ((ecount + 1) % 2) == 1;
        m_len    <= 513 + ((ecount + 1) % 2);
      end
    end
  end

  typedef struct packed {
    logic        stall;
    logic        re;
    logic        we;
    logic        chk_addr;
    logic        chk_data;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    int   j;
    int   n;
    e = '0;
    if (!m_active) begin
      e.re       = bus.cpu_read_en;
      e.we       = bus.cpu_write_en && (bus.cpu_addr_in != 16'h4014);
      e.chk_addr = 1'b1;
      e.chk_data = 1'b1;
      e.addr     = bus.cpu_addr_in;
      e.data     = bus.cpu_data_in;
    end else begin
      e.stall = 1'b1;
      j = m_k - 2 - int'(m_align);
      n = j / 2;
      if (j >= 0 && (j % 2) == 0) begin
        e.re       = 1'b1;
        e.chk_addr = 1'b1;
        e.addr     = {m_page, 8'(n)};
      end else if (j >= 0) begin
        e.we       = 1'b1;
        e.chk_addr = 1'b1;
        e.chk_data = 1'b1;
        e.addr     = 16'h2004;
        e.data     = mem_val({m_page, 8'(n)}, key);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle_checks();
    exp_t e;
    e = model_out();
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(e.stall));
    chk("dma_busy", 32'(bus.dma_busy), 32'(e.stall));
    chk("mem_read_en", 32'(bus.mem_read_en), 32'(e.re));
    chk("mem_write_en", 32'(bus.mem_write_en), 32'(e.we));
    if (e.chk_addr) chk("mem_addr_out", 32'(bus.mem_addr_out), 32'(e.addr));
    if (e.chk_data) chk("mem_data_out", 32'(bus.mem_data_out), 32'(e.data));
  endtask

  // Literal expectations requested by the stimulus process.
  int lit_req  = 0;
  int lit_done = 0;
  int lit_kind = 0;
  int lit_val  = 0;
  int cur_run  = 0;
  int last_run = 0;
  int w4014    = 0;

  task automatic literal_checks();
    case (lit_kind)
      0: begin
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_busy", 32'(bus.dma_busy), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr_out), 32'h1234);
        chk("rst_read_en", 32'(bus.mem_read_en), 32'd1);
      end
      1: begin
        chk("pass_addr", 32'(bus.mem_addr_out), 32'h0000);
        chk("pass_data", 32'(bus.mem_data_out), 32'h55);
        chk("pass_write_en", 32'(bus.mem_write_en), 32'd1);
      end
      2: chk("stall_len", 32'(last_run), 32'(lit_val));
      3: begin
        chk("oam_00", 32'(oam[0]), 32'h00);
        chk("oam_80", 32'(oam[8'h80]), 32'h80);
        chk("oam_ff", 32'(oam[8'hFF]), 32'hFF);
        chk("oam_ptr_wrap", 32'(oam_ptr), 32'h00);
        chk("no_4014_write", 32'(w4014), 32'd0);
      end
      4: chk("stall_timeout", 32'd1, 32'd0);
      default: begin
        chk("rst_mid_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_mid_busy", 32'(bus.dma_busy), 32'd0);
      end
    endcase
  endtask

  always @(negedge clk) begin
    cycle_checks();
    if (bus.cpu_stall) cur_run <= cur_run + 1;
    else if (cur_run != 0) begin
      last_run <= cur_run;
      cur_run  <= 0;
    end
    if (bus.mem_write_en && bus.mem_addr_out == 16'h4014) w4014 <= w4014 + 1;
    if (lit_req != lit_done) begin
      literal_checks();
      lit_done <= lit_req;
    end
  end

  // Inputs change 2 time units after the rising edge; checks run on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int kind, input int val);
    lit_kind = kind;
    lit_val  = val;
    lit_req++;
    tick();
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr_in  = a;
    bus.cpu_data_in  = d;
    bus.cpu_write_en = 1'b1;
    bus.cpu_read_en  = 1'b0;
    tick();
    bus.cpu_write_en = 1'b0;
  endtask

  // The next rising edge will be edge number ecount+1; the DUMMY cycle's parity equals it.
  task automatic align_parity(input bit odd);
    if (((ecount + 1) % 2) != int'(odd)) tick();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.cpu_stall && n < 700);
    if (bus.cpu_stall) req(4, 0);
    tick();
    tick();
  endtask

  task automatic transfer(input bit odd, input logic [7:0] page, input int exp_len);
    align_parity(odd);
    cpu_wr(16'h4014, page);
    wait_done();
    req(2, exp_len);
  endtask

  initial begin
    bus.cpu_addr_in  = 16'h1234;
    bus.cpu_data_in  = 8'h00;
    bus.cpu_write_en = 1'b0;
    bus.cpu_read_en  = 1'b1;
    tick();
    tick();
    req(0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    tick();
    bus.cpu_read_en  = 1'b0;

    bus.cpu_addr_in  = 16'h0000;
    bus.cpu_data_in  = 8'h55;
    bus.cpu_write_en = 1'b1;
    req(1, 0);
    bus.cpu_write_en = 1'b0;
    cpu_wr(16'h2003, 8'h00);

    transfer(1'b0, 8'h02, 513);
    req(3, 0);
    transfer(1'b1, 8'h02, 514);

    // CPU writes during a transfer must be masked, including a second trigger.
    align_parity(1'b0);
    cpu_wr(16'h4014, 8'h02);
    repeat (5) tick();
    cpu_wr(16'h0010, 8'hAA);
    cpu_wr(16'h4014, 8'h07);
    wait_done();
    req(2, 513);

    key = 8'hC3;
    transfer(1'b1, 8'h5A, 514);
    key = 8'h00;

    // Reset in the middle of a transfer, then a clean restart from index 0.
    align_parity(1'b0);
    cpu_wr(16'h4014, 8'h03);
    repeat (98) tick();
    rst = 1'b0;
    req(5, 0);
    tick();
    @(negedge clk);
    #1 rst = 1'b1;
    tick();
    cpu_wr(16'h2003, 8'h00);
    transfer(1'b0, 8'h03, 513);
    req(3, 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite DMA sequencer between the CPU core and `mem_ctrl_1_cycle`. A CPU write to $4014 latches a source page and the block stalls the CPU. It then takes over the controller's CPU-side port and copies 256 bytes from $XX00–$XXFF into sprite RAM through the $2004 data port. When idle it is a transparent pass-through.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014, CPU address that triggers a transfer.
- `OAM_DATA_ADDR`, 16'h2004, destination register address written for each byte.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_addr_in`  in  16  CPU address.
- `cpu_data_in`  in  8  CPU write data.
- `cpu_write_en`  in  1  CPU write strobe.
- `cpu_read_en`  in  1  CPU read strobe.
- `cpu_stall`  out  1  high while a transfer owns the bus; the CPU holds its state.
- `dma_busy`  out  1  high in any non-IDLE state.
- `mem_addr_out`  out  16  to `mem_ctrl_1_cycle` `cpu_addr_in`.
- `mem_data_out`  out  8  to `mem_ctrl_1_cycle` `cpu_data_in`.
- `mem_write_en`  out  1  to `mem_ctrl_1_cycle` `cpu_write_en`.
- `mem_read_en`  out  1  to `mem_ctrl_1_cycle` `cpu_read_en`.
- `mem_data_in`  in  8  from `mem_ctrl_1_cycle` `cpu_data_out`. The read is registered: data is valid in the cycle after the read cycle.

## Operation
- Registers:
  - `state` ∈ {IDLE, DUMMY, ALIGN, READ, WRITE}.
  - `page[7:0]`.
  - `idx[7:0]`.
  - `odd`: a parity flop that toggles every clock. It is 0 on the first cycle after reset release.
- Reset values: state=IDLE, page=0, idx=0, odd=0. This gives `cpu_stall`=0 and `dma_busy`=0, and `mem_*` follow the CPU inputs (pass-through).
- IDLE:
  - `mem_addr_out`/`mem_data_out`/`mem_read_en` = CPU inputs, combinationally.
  - `mem_write_en` = `cpu_write_en` AND NOT (`cpu_addr_in`==DMA_REG_ADDR). The $4014 write is consumed, never forwarded.
- Trigger: at a rising edge in IDLE with `cpu_write_en`=1 and `cpu_addr_in`==DMA_REG_ADDR:
  - page ← `cpu_data_in`, idx ← 0, state ← DUMMY.
- DUMMY: no memory access (all `mem_*` enables 0). Next state is ALIGN if `odd`=1 during this cycle, otherwise READ.
- ALIGN: no memory access; next state is READ.
- READ: `mem_addr_out`={page, idx}, `mem_read_en`=1, `mem_write_en`=0; next state is WRITE.
- WRITE:
  - `mem_addr_out`=OAM_DATA_ADDR, `mem_data_out`=`mem_data_in` (combinational), `mem_write_en`=1, `mem_read_en`=0.
  - If idx==8'hFF, state ← IDLE; otherwise idx ← idx+1 and state ← READ.
- While state≠IDLE, all CPU strobes are masked: no CPU access reaches memory. A second $4014 write is ignored and `page` is unchanged.
- The destination index is the controller's own OAMADDR ($2003 pointer, auto-increment). This block never writes $2003. Writes past 8'hFF wrap in sprite RAM.
- Any page value 00–FF is legal, including PPU-register or unmapped pages. There is no special handling.
- An asynchronous reset mid-transfer forces IDLE immediately. `cpu_stall` drops without waiting for a clock, and the partial transfer is abandoned.

## Timing
- Trigger edge E0. `cpu_stall` and `dma_busy` go high for the cycle after E0 and stay high through the last WRITE. Both are registered outputs decoded from `state`.
- Stall length is exactly 513 cycles (DUMMY + 256×(READ,WRITE)) if `odd`=0 in DUMMY. It is 514 cycles if `odd`=1.
- Byte n is read in cycle 2+2n (or 3+2n when aligned) after E0 and written in the following cycle.
- In the first cycle after the final WRITE, state=IDLE, `cpu_stall`=0 and pass-through resumes.

## Test plan
- Reset: hold `rst`=0 with `cpu_addr_in`=16'h1234 and `cpu_read_en`=1.
  - Expect `cpu_stall`=0, `dma_busy`=0, `mem_addr_out`=16'h1234, `mem_read_en`=1.
  - Writing 8'h55 to $0000 in IDLE appears on `mem_*` unchanged.
- Even-start transfer: memory model returns addr[7:0]. Write 8'h02 to $4014 with `odd`=0 in DUMMY.
  - `cpu_stall` is high for exactly 513 cycles.
  - Reads hit 16'h0200..16'h02FF in order.
  - 256 writes go to 16'h2004 with data 8'h00..8'hFF.
  - `mem_write_en` is never asserted for $4014.
- Odd-start transfer: same stimulus, triggered one cycle later so `odd`=1 in DUMMY.
  - Stall lasts 514 cycles; a single ALIGN cycle has no strobes; data is identical.
- Masking: during a transfer, drive a CPU write of 8'hAA to $0010, then a write of 8'h07 to $4014.
  - Neither reaches `mem_*`.
  - The transfer continues from page 8'h02 and completes normally.
- Reset mid-op: assert `rst`=0 at cycle 100 of a transfer.
  - `cpu_stall` goes 0 immediately.
  - After release, a new trigger with page 8'h03 runs a full 513/514-cycle transfer starting at idx 0.
- Integration with `mem_ctrl_1_cycle`:
  - Fill CPU RAM 16'h0300..16'h03FF with addr[7:0], write 8'h00 to $2003, then write 8'h03 to $4014.
  - After the stall ends, PPU reads of `spram_ppu_addr` 0..255 return 8'h00..8'hFF.
